// File: rtl/pe_time_mean_acc.sv
// Predicted-mean accumulator: weighted sum of N_SIGMA propagated sigma points per batch.
// Optional MEAN_SAT_EN saturates each output element instead of wrapping.
module pe_time_mean_acc #(
  parameter int unsigned N_STATE = 5,
  parameter int unsigned N_SIGMA = 11,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FRAC    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_clk,
  input  logic [N_STATE*WIDTH-1:0]   x_in,
  input  logic                       x_in_valid,
  input  logic [WIDTH-1:0]           w0,
  input  logic [WIDTH-1:0]           wi,
  output logic [N_STATE*WIDTH-1:0]   x_mean,
  output logic                       x_mean_valid,
  output logic [3:0]                 sigma_idx
);

  localparam int unsigned VW = N_STATE * WIDTH;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned IW = 4;
  localparam int unsigned HB = WIDTH + FRAC - 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                state;
  logic signed [PW-1:0]  acc [N_STATE];
  logic signed [WIDTH-1:0] wi_r;

  logic                  accept_c;
  logic                  last_c;
  logic signed [WIDTH-1:0] wt_c;
  logic signed [PW-1:0]  p_c   [N_STATE];
  logic signed [PW-1:0]  sum_c [N_STATE];
  logic [VW-1:0]         mean_c;

  // Reduce a Q32.32 sum to Q16.16, flooring; clamp when the integer part overflows.
  function automatic logic [WIDTH-1:0] fit(input logic signed [PW-1:0] s);
`ifdef MEAN_SAT_EN
    logic signed [PW-1:0] hi;
    hi = s >>> HB;
    if ((hi != '0) && (hi != '1))
      return (s < 0) ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    return WIDTH'(s >>> FRAC);
  endfunction

  // Point 0 uses the live w0 and overwrites the accumulator; later points use the sampled wi.
  always_comb begin
    accept_c = x_in_valid & en_clk;
    last_c   = (sigma_idx == IW'(N_SIGMA - 1));
    wt_c     = (state == IDLE) ? $signed(w0) : wi_r;
    mean_c   = '0;
    for (int e = 0; e < N_STATE; e++) begin
      p_c[e]   = PW'($signed(x_in[e*WIDTH +: WIDTH])) * PW'(wt_c);
      sum_c[e] = (state == IDLE) ? p_c[e] : acc[e] + p_c[e];
      mean_c[e*WIDTH +: WIDTH] = fit(sum_c[e]);
    end
  end

  // Batch sequencing, accumulation and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      sigma_idx    <= '0;
      wi_r         <= '0;
      x_mean       <= '0;
      x_mean_valid <= 1'b0;
      for (int e = 0; e < N_STATE; e++) acc[e] <= '0;
    end else if (en_clk) begin
      x_mean_valid <= 1'b0;
      if (accept_c) begin
        if (state == IDLE) wi_r <= $signed(wi);
        for (int e = 0; e < N_STATE; e++) acc[e] <= sum_c[e];
        if (last_c) begin
          state        <= IDLE;
          sigma_idx    <= '0;
          x_mean       <= mean_c;
          x_mean_valid <= 1'b1;
        end else begin
          state     <= ACCUM;
          sigma_idx <= IW'(sigma_idx + IW'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_time_mean_acc.sv
// Scoreboard bench for pe_time_mean_acc: a reference model pushes expected means on drive,
// the output monitor pops and compares them together with result latency.
module tb_pe_time_mean_acc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en_clk;
  logic [159:0] x_in;
  logic         x_in_valid;
  logic [31:0]  w0;
  logic [31:0]  wi;
  logic [159:0] x_mean;
  logic         x_mean_valid;
  logic [3:0]   sigma_idx;

  pe_time_mean_acc dut (
    .clk(clk), .rst_n(rst_n), .en_clk(en_clk), .x_in(x_in), .x_in_valid(x_in_valid),
    .w0(w0), .wi(wi), .x_mean(x_mean), .x_mean_valid(x_mean_valid), .sigma_idx(sigma_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [159:0] vec;
    int           cyc;
  } exp_t;

  exp_t   sb[$];
  int     pulse_q[$];
  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     m_idx = 0;
  longint m_acc [5];
  logic signed [31:0] m_wi;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Q32.32 sum to Q16.16 output element.
  function automatic logic [31:0] ref_fit(input longint s);
`ifdef MEAN_SAT_EN
    if (s >= 64'sh0000_8000_0000_0000) return 32'h7FFF_FFFF;
    if (s <  -64'sh0000_8000_0000_0000) return 32'h8000_0000;
`endif
    return s[47:16];
  endfunction

  task automatic model_accept(input logic [159:0] x, input logic [31:0] a0, input logic [31:0] ai);
    logic signed [31:0] wt;
    logic signed [31:0] xe;
    longint p;
    exp_t   ex;
    if (m_idx == 0) begin
      m_wi = ai;
      wt   = a0;
    end else begin
      wt = m_wi;
    end
    for (int e = 0; e < 5; e++) begin
      xe = x[e*32 +: 32];
      p  = longint'(xe) * longint'(wt);
      m_acc[e] = (m_idx == 0) ? p : m_acc[e] + p;
    end
    if (m_idx == 10) begin
      for (int e = 0; e < 5; e++) ex.vec[e*32 +: 32] = ref_fit(m_acc[e]);
      ex.cyc = cyc + 1;
      sb.push_back(ex);
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  task automatic drive(input logic v, input logic en, input logic [159:0] x,
                       input logic [31:0] a0, input logic [31:0] ai);
    x_in = x; x_in_valid = v; en_clk = en; w0 = a0; wi = ai;
    if (v && en) model_accept(x, a0, ai);
    @(posedge clk); #1;
    chk("sigma_idx", 160'(sigma_idx), 160'(m_idx));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, '0, w0, wi);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; x_in_valid = 1'b0; en_clk = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_idx = 0;
  endtask

  function automatic logic [159:0] rand_vec();
    logic [159:0] v;
    for (int e = 0; e < 5; e++) v[e*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [159:0] splat(input logic [31:0] s);
    return {5{s}};
  endfunction

  // Output monitor: every pulse must match the oldest pending expectation, on time.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && x_mean_valid === 1'b1) begin
      pulse_q.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 160'(1), 160'(0));
      end else begin
        exp_t ex;
        ex = sb.pop_front();
        chk("x_mean", x_mean, ex.vec);
        chk("latency", 160'(cyc), 160'(ex.cyc));
      end
    end
  end

  initial begin
    logic [159:0] v;
    x_in = '0; x_in_valid = 1'b0; en_clk = 1'b1; w0 = '0; wi = '0; rst_n = 1'b0;
    for (int e = 0; e < 5; e++) m_acc[e] = 0;
    do_reset();
    chk("rst_x_mean", x_mean, '0);
    chk("rst_valid", 160'(x_mean_valid), 160'(0));
    chk("rst_idx", 160'(sigma_idx), 160'(0));

    // Point 0 weight 1.0, others weight 0.
    v = rand_vec(); v[159:128] = 32'h0003_8000;
    drive(1'b1, 1'b1, v, 32'h0001_0000, 32'h0);
    for (int i = 1; i < 11; i++) drive(1'b1, 1'b1, rand_vec(), 32'h0001_0000, 32'h0);
    chk("t1_valid", 160'(x_mean_valid), 160'(1));
    chk("t1_xi", 160'(x_mean[159:128]), 160'(32'h0003_8000));
    idle(2);
    chk("t1_pulse_once", 160'(x_mean_valid), 160'(0));

    // Negative w0 with fractional wi: eta = -8 + 10*1 = 2.
    for (int i = 0; i < 11; i++) begin
      v = rand_vec(); v[95:64] = 32'h0008_0000;
      drive(1'b1, 1'b1, v, 32'hFFFF_0000, 32'h0000_2000);
    end
    chk("t2_eta", 160'(x_mean[95:64]), 160'(32'h0002_0000));
    idle(1);

    // Back-to-back batches, no bubble.
    pulse_q.delete();
    for (int i = 0; i < 22; i++) drive(1'b1, 1'b1, rand_vec(), 32'h0000_1000, 32'h0000_1000);
    idle(2);
    chk("t3_pulses", 160'(pulse_q.size()), 160'(2));
    if (pulse_q.size() == 2) chk("t3_spacing", 160'(pulse_q[1] - pulse_q[0]), 160'(11));

    // Partial batch discarded by reset; enable gaps ignore valid points.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, rand_vec(), 32'h0001_0000, 32'h0001_0000);
    do_reset();
    chk("t4_rst_idx", 160'(sigma_idx), 160'(0));
    pulse_q.delete();
    for (int i = 0; i < 11; i++) begin
      if (i == 4) for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, rand_vec(), 32'h0001_0000, 32'h0001_0000);
      drive(1'b1, 1'b1, splat(32'h0001_0000), 32'h0001_0000, 32'h0001_0000);
    end
    chk("t4_mean", x_mean, splat(32'h000B_0000));
    idle(2);
    chk("t4_single_pulse", 160'(pulse_q.size()), 160'(1));

    // Overflow of the integer range.
    for (int i = 0; i < 11; i++) drive(1'b1, 1'b1, splat(32'h7FFF_0000), 32'h0001_0000, 32'h0001_0000);
`ifdef MEAN_SAT_EN
    chk("t5_sat", x_mean, splat(32'h7FFF_FFFF));
`else
    chk("t5_wrap", x_mean, splat(32'h7FF5_0000));
`endif
    idle(1);

    // Weights changed after point 0 must not affect the batch.
    drive(1'b1, 1'b1, splat(32'h0001_0000), 32'h0001_0000, 32'h0001_0000);
    for (int i = 1; i < 11; i++) drive(1'b1, 1'b1, splat(32'h0001_0000), 32'h0002_0000, 32'h0003_0000);
    chk("t6_mean", x_mean, splat(32'h000B_0000));

    idle(3);
    chk("sb_empty", 160'(sb.size()), 160'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=0", cyc);
    $fatal(1);
  end

endmodule
